mux_nx1_pipe: RTL



---
 rtl/mips_dp_pkg.sv | 16 +
 rtl/dp_skid_buf.sv | 121 ++++++++++++
 rtl/mux_nx1_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/mips_dp_pkg.sv
// Shared definitions for the pipelined datapath select stages.
// Contents:
//   buf_state_e : occupancy of the two-entry skid buffer (EMPTY/BUSY/FULL)
//   WORD_W      : native datapath word width
package mips_dp_pkg;

  // Buffer occupancy: EMPTY = no beat, BUSY = main only, FULL = main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  localparam int WORD_W = 32;

endpackage : mips_dp_pkg

// File: rtl/dp_skid_buf.sv
// Two-entry skid buffer with valid/ready on both sides.
// in_ready depends on state only, so there is no combinational path from
// out_ready back to the upstream stage. The head of the buffer is always the
// main register; the skid register only ever refills main, keeping FIFO order.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   flush                   : synchronous drop of all buffered beats
//   in_data/in_valid/in_ready    : upstream handshake, PW-bit payload
//   out_data/out_valid/out_ready : downstream handshake, PW-bit payload
module dp_skid_buf
  import mips_dp_pkg::*;
#(
  parameter int PW = 34
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [PW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [PW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  buf_state_e    state_q, state_d;
  logic [PW-1:0] main_q, main_d;
  logic [PW-1:0] skid_q, skid_d;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          accept_s;
  logic          pop_s;

  // State and payload registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and next payload; flush wins and discards a same-cycle accept.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    accept_s = in_valid & in_ready_s;
    pop_s    = out_valid_s & out_ready;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_BUSY;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (accept_s && pop_s) begin
            main_d = in_data;
          end else if (accept_s) begin
            // Head is stalled: park the new beat behind it.
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (pop_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the head can move.
          if (pop_s) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    case (state_q)
      ST_EMPTY: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
      ST_BUSY: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b1;
      end
      ST_FULL: begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b1;
      end
      default: begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = main_q;

endmodule : dp_skid_buf

// File: rtl/mux_nx1_pipe.sv
// Registered N:1 operand select stage with valid/ready handshake.
// The selected word and the sel value that chose it travel together through
// a two-entry skid buffer. A select index >= N_IN (only reachable when N_IN
// is not a power of two) captures an all-zero word and raises sel_err for
// one cycle after the accept.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronous drop of all buffered beats
//   in_flat             : N_IN words, word k at [k*WIDTH +: WIDTH]
//   sel                 : index of the word to capture this beat
//   in_valid/in_ready   : upstream handshake
//   out_data/out_sel    : head word and the sel that produced it
//   out_valid/out_ready : downstream handshake
//   sel_err             : pulse, previous cycle accepted an out-of-range sel
module mux_nx1_pipe
  import mips_dp_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [N_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  localparam int              PW       = WIDTH + SEL_W;
  localparam logic [SEL_W:0]  N_IN_EXT = (SEL_W + 1)'(N_IN);

  logic [WIDTH-1:0] word_s;
  logic             in_range_s;
  logic [PW-1:0]    payload_s;
  logic [PW-1:0]    head_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             sel_err_q, sel_err_d;

  // Range check, widened by one bit so N_IN itself is representable.
  always_comb begin
    in_range_s = ({1'b0, sel} < N_IN_EXT);
  end

  // One-hot OR select; an out-of-range index matches nothing and yields zero.
  always_comb begin
    word_s = {WIDTH{1'b0}};
    for (int k = 0; k < N_IN; k++) begin
      word_s = word_s | ((sel == SEL_W'(k)) ? in_flat[k*WIDTH +: WIDTH]
                                            : {WIDTH{1'b0}});
    end
  end

  // Payload and error next-state; a flushed beat never reports an error.
  always_comb begin
    payload_s = {sel, word_s};
    accept_s  = in_valid & in_ready_s;
    if (flush) begin
      sel_err_d = 1'b0;
    end else begin
      sel_err_d = accept_s & ~in_range_s;
    end
  end

  // Error pulse register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  dp_skid_buf #(
    .PW (PW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (payload_s),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .out_data  (head_s),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign in_ready = in_ready_s;
  assign out_sel  = head_s[PW-1 -: SEL_W];
  assign out_data = head_s[WIDTH-1:0];
  assign sel_err  = sel_err_q;

endmodule : mux_nx1_pipe
